// File: rtl/ram_dp_bytewise.sv
// ram_dp_bytewise: simple dual-port RAM (one write port, one read port, single clock)
// with per-byte write enables, 1- or 2-cycle read latency, selectable read-during-write
// behaviour and a built-in clear sequencer that fills every word with INIT_VALUE.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   write_en       write request (ignored while clearing)
//   write_address  write word address
//   data_in        write data
//   byte_en        per-byte write mask, bit i covers data_in[8i+7:8i]
//   read_en        read request (ignored while clearing)
//   read_address   read word address
//   data_out       read data, holds between reads
//   read_valid     one-cycle pulse aligned with each new data_out
//   init_start     request a clear sequence (accepted only when idle)
//   init_busy      high while the clear sequence runs
module ram_dp_bytewise #(
  parameter int unsigned          ADD_SIZE       = 11,
  parameter int unsigned          DATA_SIZE      = 32,
  parameter int unsigned          READ_LATENCY   = 1,
  parameter bit                   RDW_MODE       = 1'b0,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic [ADD_SIZE-1:0]    write_address,
  input  logic [DATA_SIZE-1:0]   data_in,
  input  logic [DATA_SIZE/8-1:0] byte_en,
  input  logic                   read_en,
  input  logic [ADD_SIZE-1:0]    read_address,
  output logic [DATA_SIZE-1:0]   data_out,
  output logic                   read_valid,
  input  logic                   init_start,
  output logic                   init_busy
);

  localparam int unsigned Depth    = 1 << ADD_SIZE;
  localparam int unsigned NumBytes = DATA_SIZE / 8;

  // Elaboration-time parameter checks.
  if ((DATA_SIZE % 8) != 0 || DATA_SIZE == 0) begin : g_bad_data_size
    $error("ram_dp_bytewise: DATA_SIZE must be a non-zero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
    $error("ram_dp_bytewise: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {StIdle, StClear} state_e;

  state_e              state_q;
  logic [ADD_SIZE-1:0] cnt_q;
  logic                busy_q;

  logic [DATA_SIZE-1:0] mem [Depth];

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q   <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (init_start) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          // Counter is exactly ADD_SIZE bits, so it wraps back to 0 after DEPTH-1.
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = busy_q;

  logic idle;
  assign idle = (state_q == StIdle);

  // ---------------------------------------------------------------------------
  // Memory write port: the clear sequencer takes over the port while running.
  // ---------------------------------------------------------------------------
  logic                  mem_we;
  logic [ADD_SIZE-1:0]   mem_waddr;
  logic [DATA_SIZE-1:0]  mem_wdata;
  logic [NumBytes-1:0]   mem_be;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_address;
    mem_wdata = data_in;
    mem_be    = byte_en;
    if (!idle) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VALUE;
      mem_be    = '1;
    end else begin
      mem_we    = write_en;
    end
  end

  // The array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (mem_be[i]) begin
          mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: the array is read combinationally at the accepting edge, so the
  // raw word is always the pre-write contents (read-first). Write-first mode
  // forwards the enabled bytes of the colliding write.
  // ---------------------------------------------------------------------------
  logic                 rd_accept;
  logic                 collide;
  logic [DATA_SIZE-1:0] rd_raw;
  logic [DATA_SIZE-1:0] rd_merged;
  logic [DATA_SIZE-1:0] rd_word;

  assign rd_accept = idle && read_en;
  assign collide   = idle && write_en && read_en && (write_address == read_address);
  assign rd_raw    = mem[read_address];

  always_comb begin
    rd_merged = rd_raw;
    for (int i = 0; i < NumBytes; i++) begin
      if (byte_en[i]) begin
        rd_merged[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  assign rd_word = (RDW_MODE && collide) ? rd_merged : rd_raw;

  logic [DATA_SIZE-1:0] data_out_q;
  logic                 read_valid_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 s1_valid_q;
    logic [DATA_SIZE-1:0] s1_data_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_valid_q   <= 1'b0;
        s1_data_q    <= '0;
        read_valid_q <= 1'b0;
        data_out_q   <= '0;
      end else begin
        s1_valid_q   <= rd_accept;
        if (rd_accept) begin
          s1_data_q <= rd_word;
        end
        // Reads already in flight complete even if a clear has started.
        read_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          data_out_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        read_valid_q <= 1'b0;
        data_out_q   <= '0;
      end else begin
        read_valid_q <= rd_accept;
        if (rd_accept) begin
          data_out_q <= rd_word;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_ram_dp_bytewise.sv
// Self-checking bench for ram_dp_bytewise. Two instances share all stimulus:
// instance 0 uses defaults (latency 1, read-first), instance 1 uses latency 2 and
// write-first. A reference model predicts each read result and its due edge;
// a negedge monitor pops and compares whenever read_valid is seen.
module tb_ram_dp_bytewise;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          write_en = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] byte_en = '0;
  logic          read_en = 1'b0;
  logic [AW-1:0] read_address = '0;
  logic          init_start = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic          rv0, rv1, busy0, busy1;

  always #5 clk = ~clk;

  ram_dp_bytewise u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .write_address (write_address),
    .data_in       (data_in),
    .byte_en       (byte_en),
    .read_en       (read_en),
    .read_address  (read_address),
    .data_out      (dout0),
    .read_valid    (rv0),
    .init_start    (init_start),
    .init_busy     (busy0)
  );

  ram_dp_bytewise #(
    .READ_LATENCY (2),
    .RDW_MODE     (1'b1)
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .write_address (write_address),
    .data_in       (data_in),
    .byte_en       (byte_en),
    .read_en       (read_en),
    .read_address  (read_address),
    .data_out      (dout1),
    .read_valid    (rv1),
    .init_start    (init_start),
    .init_busy     (busy1)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] held0 = '0;
  logic [DW-1:0] held1 = '0;
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left = DEPTH;
  logic          exp_busy = 1'b1;
  int            edge_cnt = 0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_cnt, act, req);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic fill_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // Reference model of one accepted edge, at the level of whole operations.
  task automatic model_edge(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                            input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                            input logic ist);
    logic [DW-1:0] old;
    if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (re) begin
        old = mem_m[ra];
        q0.push_back('{data: old, due: edge_cnt});
        q1.push_back('{data: (we && wa == ra) ? merge(old, din, be) : old, due: edge_cnt + 1});
      end
      if (we) mem_m[wa] = merge(mem_m[wa], din, be);
      if (ist) begin
        fill_model();
        clear_left = DEPTH;
      end
    end
    exp_busy = (clear_left > 0);
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                      input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                      input logic ist);
    write_en      = we;
    write_address = wa;
    data_in       = din;
    byte_en       = be;
    read_en       = re;
    read_address  = ra;
    init_start    = ist;
    @(posedge clk);
    edge_cnt++;
    model_edge(we, wa, din, be, re, ra, ist);
    #1;
    write_en   = 1'b0;
    read_en    = 1'b0;
    init_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    step(1'b1, a, d, be, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic wait_clear();
    while (clear_left > 0) idle(1);
    chk("clear_done_busy0", busy0, 1'b0);
  endtask

  // Called just after an edge; reset takes effect asynchronously.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    held0 = '0;
    held1 = '0;
    clear_left = DEPTH;
    exp_busy = 1'b1;
    fill_model();
    #1;
    chk("async_rst_dout0", dout0, '0);
    chk("async_rst_rv0", rv0, 1'b0);
    chk("async_rst_dout1", dout1, '0);
    chk("async_rst_rv1", rv1, 1'b0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares each read_valid pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) chk("unexpected_valid0", rv0, 1'b0);
      else begin
        e = q0.pop_front();
        chk("valid_timing0", edge_cnt, e.due);
        chk("read_data0", dout0, e.data);
        held0 = e.data;
      end
    end else begin
      if (q0.size() > 0 && q0[0].due <= edge_cnt) begin
        chk("missing_valid0", rv0, 1'b1);
        void'(q0.pop_front());
      end
      chk("data_hold0", dout0, held0);
    end
    if (rv1) begin
      if (q1.size() == 0) chk("unexpected_valid1", rv1, 1'b0);
      else begin
        e = q1.pop_front();
        chk("valid_timing1", edge_cnt, e.due);
        chk("read_data1", dout1, e.data);
        held1 = e.data;
      end
    end else begin
      if (q1.size() > 0 && q1[0].due <= edge_cnt) begin
        chk("missing_valid1", rv1, 1'b1);
        void'(q1.pop_front());
      end
      chk("data_hold1", dout1, held1);
    end
    chk("init_busy0", busy0, exp_busy);
    chk("init_busy1", busy1, exp_busy);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_model();
    // Defaults: 2-cycle reset, then a full clear, then read the top word.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
    rst = 1'b1;
    wait_clear();
    rd(11'h7FF);
    idle(2);

    // Full write then read, data held afterwards.
    wr(11'd10, 32'd244, 4'hF);
    rd(11'd10);
    idle(11);

    // Byte enables.
    wr(11'd5, 32'hAABBCCDD, 4'hF);
    wr(11'd5, 32'h11223344, 4'b0101);
    rd(11'd5);
    idle(3);

    // Same-address collision, then a follow-up read.
    step(1'b1, 11'd10, 32'h55, 4'hF, 1'b1, 11'd10, 1'b0);
    rd(11'd10);
    idle(3);

    // Clear requested while a read is accepted; ops during clear are dropped.
    wr(11'd3, 32'hDEADBEEF, 4'hF);
    rd(11'd3);
    idle(3);
    step(1'b0, '0, '0, '0, 1'b1, 11'd3, 1'b1);
    step(1'b1, 11'd7, 32'd9, 4'hF, 1'b1, 11'd7, 1'b0);
    wait_clear();
    rd(11'd3);
    rd(11'd7);
    idle(3);

    // Reset in the middle of a clear, at clear count 100.
    wr(11'd3, 32'hDEADBEEF, 4'hF);
    rd(11'd3);
    idle(3);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    while (DEPTH - clear_left < 100) idle(1);
    do_reset(2);
    wait_clear();
    rd(11'd3);
    idle(3);

    // Back-to-back reads for throughput.
    wr(11'd1, 32'd10, 4'hF);
    wr(11'd2, 32'd20, 4'hF);
    wr(11'd3, 32'd30, 4'hF);
    rd(11'd1);
    rd(11'd2);
    rd(11'd3);
    idle(4);

    // Random traffic on a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
           NB'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), 1'b0);
    end
    idle(4);
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
